// File: rtl/sweep_ctrl_pkg.sv
// rtl/sweep_ctrl_pkg.sv - shared state encoding and default widths for the sweep sequencer
package sweep_ctrl_pkg;

  localparam int DEF_BITS     = 4;
  localparam int DEF_CYC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/updown_count_core.sv
// rtl/updown_count_core.sv - up/down counter datapath with clear over enable
module updown_count_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic         up,
  output logic [W-1:0] Q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      Q <= '0;
    end else if (enable) begin
      Q <= up ? (Q + W'(1)) : (Q - W'(1));
    end
  end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// rtl/sweep_counter_ctrl.sv - triangle sweep sequencer driving the up/down counter core
module sweep_counter_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int CYC_BITS = DEF_CYC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BITS-1:0]     limit,
  input  logic [CYC_BITS-1:0] cycles,
  input  logic                pause,
  output logic                busy,
  output logic                enable,
  output logic                up,
  output logic [BITS-1:0]     count,
  output logic [CYC_BITS-1:0] sweep_cnt,
  output logic                done
);

  state_t              state;
  logic [BITS-1:0]     lim_r;
  logic [CYC_BITS-1:0] cyc_r;
  logic [BITS-1:0]     count_inc;
  logic [BITS-1:0]     count_dec;
  logic [CYC_BITS-1:0] sweep_inc;
  logic                clear;

  assign count_inc = count + BITS'(1);
  assign count_dec = count - BITS'(1);
  assign sweep_inc = sweep_cnt + CYC_BITS'(1);

  assign busy   = (state != IDLE);
  assign up     = (state == UP);
  assign enable = ((state == UP) || (state == DOWN)) && !pause;
  // Count is pinned to zero whenever the counter is not sweeping.
  assign clear  = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lim_r     <= '0;
      cyc_r     <= '0;
      sweep_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lim_r     <= limit;
            cyc_r     <= cycles;
            sweep_cnt <= '0;
            state     <= ((limit == '0) || (cycles == '0)) ? DONE : UP;
          end
        end
        UP: begin
          if (!pause && (count_inc == lim_r)) begin
            state <= DOWN;
          end
        end
        DOWN: begin
          // Reaching zero closes one sweep; either start another or finish.
          if (!pause && (count_dec == '0)) begin
            sweep_cnt <= sweep_inc;
            state     <= (sweep_inc == cyc_r) ? DONE : UP;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  updown_count_core #(
    .W(BITS)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .up     (up),
    .Q      (count)
  );

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// tb/tb_sweep_counter_ctrl.sv - self-checking bench for the sweep sequencer
module tb_sweep_counter_ctrl;

  localparam int BITS     = 4;
  localparam int CYC_BITS = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [BITS-1:0]     limit;
  logic [CYC_BITS-1:0] cycles;
  logic                pause;
  logic                busy;
  logic                enable;
  logic                up;
  logic [BITS-1:0]     count;
  logic [CYC_BITS-1:0] sweep_cnt;
  logic                done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sweep_counter_ctrl #(
    .BITS     (BITS),
    .CYC_BITS (CYC_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .limit     (limit),
    .cycles    (cycles),
    .pause     (pause),
    .busy      (busy),
    .enable    (enable),
    .up        (up),
    .count     (count),
    .sweep_cnt (sweep_cnt),
    .done      (done)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic [3:0] lim;
    logic [7:0] cyc;
    logic       pz;
    int         cnt;
    int         sw;
    logic       bsy;
    logic       u;
    logic       en;
    logic       dn;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l, input int c);
    start  = 1'b1;
    limit  = BITS'(l);
    cycles = CYC_BITS'(c);
    edge1();
    start  = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int c, input int s, input logic b,
                         input logic u, input logic en, input logic d);
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " sweep_cnt"}, 32'(sweep_cnt), 32'(s));
    chk({tag, " busy"}, 32'(busy), 32'(b));
    chk({tag, " up"}, 32'(up), 32'(u));
    chk({tag, " enable"}, 32'(enable), 32'(en));
    chk({tag, " done"}, 32'(done), 32'(d));
  endtask

  function automatic int tri_val(input int kk, input int ll);
    int p;
    p = kk % (2 * ll);
    return (p <= ll) ? p : (2 * ll - p);
  endfunction

  int exp_rep[12];
  int e, peak;
  int ph, k, ml, mc, swe;
  logic dne;
  logic hit_done;

  initial begin
    reset = 1'b1; start = 1'b0; limit = '0; cycles = '0; pause = 1'b0;

    // inputs applied before an edge, outputs expected just after it
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 3, 1, 0, 0, 0, 1, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 2, 0, 1, 1, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 3, 0, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 5, 0, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    edge1();
    edge1();
    for (int i = 0; i < 15; i++) begin
      reset  = tbl[i].rst;
      start  = tbl[i].st;
      limit  = tbl[i].lim;
      cycles = tbl[i].cyc;
      pause  = tbl[i].pz;
      edge1();
      chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].sw, tbl[i].bsy,
              tbl[i].u, tbl[i].en, tbl[i].dn);
    end
    start = 1'b0;

    // repeat: limit=2, cycles=3
    exp_rep = '{1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0};
    do_start(2, 3);
    for (int i = 0; i < 12; i++) begin
      edge1();
      chk($sformatf("rep count e%0d", i + 1), 32'(count), 32'(exp_rep[i]));
      chk($sformatf("rep sweep e%0d", i + 1), 32'(sweep_cnt), 32'((i + 1) / 4));
      chk($sformatf("rep done e%0d", i + 1), 32'(done), 32'(0));
    end
    edge1();
    chk("rep done e13", 32'(done), 32'(1));
    chk("rep busy e13", 32'(busy), 32'(0));

    // pause with ignored start: limit=4, cycles=1
    do_start(4, 1);
    edge1();
    edge1();
    chk("pz count pre", 32'(count), 32'(2));
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      limit = 4'd9;
      edge1();
      chk($sformatf("pz count %0d", i), 32'(count), 32'(2));
      chk($sformatf("pz enable %0d", i), 32'(enable), 32'(0));
      chk($sformatf("pz up %0d", i), 32'(up), 32'(1));
    end
    start = 1'b0;
    pause = 1'b0;
    e = 5; peak = 2; hit_done = 1'b0;
    while (!hit_done && e < 100) begin
      edge1();
      e++;
      if (32'(count) > peak) peak = 32'(count);
      hit_done = done;
    end
    chk("pz done edge", 32'(e), 32'(12));
    chk("pz peak", 32'(peak), 32'(4));

    // reset mid-run: limit=5, cycles=2, reset at count=3 in DOWN
    do_start(5, 2);
    for (int i = 0; i < 7; i++) edge1();
    chk("rst pre count", 32'(count), 32'(3));
    chk("rst pre up", 32'(up), 32'(0));
    reset = 1'b1;
    edge1();
    chk_all("rst", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    edge1();
    chk_all("rst post", 0, 0, 0, 0, 0, 0);

    // full range: limit=15, cycles=1
    do_start(15, 1);
    e = 0; hit_done = 1'b0;
    while (!hit_done && e < 100) begin
      edge1();
      e++;
      if (e == 15) chk("full peak", 32'(count), 32'(15));
      if (e == 16) chk("full no wrap", 32'(count), 32'(14));
      hit_done = done;
    end
    chk("full done edge", 32'(e), 32'(31));
    chk("full count end", 32'(count), 32'(0));

    // randomized run against a sweep-position model
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    ph = 0; k = 0; ml = 0; mc = 0; swe = 0; dne = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 99) == 0);
      start  = ($urandom_range(0, 3) == 0);
      pause  = ($urandom_range(0, 4) == 0);
      limit  = ($urandom_range(0, 9) == 0) ? 4'd15 : BITS'($urandom_range(0, 5));
      cycles = CYC_BITS'($urandom_range(0, 3));
      if (reset) begin
        ph = 0; swe = 0; dne = 1'b0;
      end else begin
        dne = (ph == 2);
        case (ph)
          0: if (start) begin
               ml = int'(limit); mc = int'(cycles); swe = 0; k = 0;
               ph = (ml == 0 || mc == 0) ? 2 : 1;
             end
          1: if (!pause) begin
               k++;
               swe = k / (2 * ml);
               if (k == 2 * ml * mc) ph = 2;
             end
          default: ph = 0;
        endcase
      end
      edge1();
      chk_all("rnd", (ph == 1) ? tri_val(k, ml) : 0, swe, ph != 0,
              (ph == 1) && ((k % (2 * ml)) < ml), (ph == 1) && !pause, dne);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sweep_counter_ctrl.md
Name: sweep_counter_ctrl

Overview:
- Sequencer for the team's up/down counter datapath.
- Runs a programmable triangle sweep: count 0 up to LIMIT, then back down to 0, repeated CYCLES times. Asserts a one-cycle done pulse when finished.
- Drives the counter's enable/up controls internally and exposes them for observation.
- Sits between a host-side start/done handshake and the counter; it is the block that decides when and in which direction the counter moves.

Parameters:
- BITS, 4, width of the count value and of the limit.
- CYC_BITS, 8, width of the sweep-repeat count.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- limit  input  BITS  sweep peak value; latched on accepted start.
- cycles  input  CYC_BITS  number of full sweeps; latched on accepted start.
- pause  input  1  freezes count, sweep counter and state while high.
- busy  output  1  high in every state except IDLE.
- enable  output  1  counter enable: (state==UP or state==DOWN) and !pause.
- up  output  1  direction: 1 in UP, 0 otherwise.
- count  output  BITS  current counter value.
- sweep_cnt  output  CYC_BITS  completed sweeps in the current run.
- done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset (synchronous, active-high) on the next rising edge:
  - state=IDLE; count=0, sweep_cnt=0, done=0, busy=0, enable=0, up=0.
  - Latched limit and cycles cleared to 0.
  - Reset wins over every other input, including mid-sweep and while paused.
- States: IDLE, UP, DOWN, DONE.
- IDLE:
  - count held at 0.
  - start=1 latches lim_r=limit and cyc_r=cycles, and clears sweep_cnt.
  - If lim_r==0 or cyc_r==0, next state is DONE; otherwise next state is UP.
- UP, per edge with pause=0:
  - count <= count+1.
  - If count+1==lim_r, next state is DOWN.
- DOWN, per edge with pause=0:
  - count <= count-1.
  - If count-1==0, sweep_cnt <= sweep_cnt+1.
  - Then: if sweep_cnt+1==cyc_r, go to DONE; else go to UP.
- DONE:
  - done=1 for exactly one cycle; count=0.
  - Next state is IDLE unconditionally; pause is ignored.
- pause=1 in UP or DOWN: state, count and sweep_cnt hold; enable=0; up keeps its state value.
- start while busy is ignored; limit and cycles changes while busy have no effect.
- Arithmetic and boundaries:
  - count never wraps: it is bounded to 0..lim_r.
  - lim_r = 2^BITS-1 is legal and peaks at all-ones without overflow.
  - sweep_cnt saturates at cyc_r by construction.
- Timing per sweep: 2*lim_r counting edges. Run length from the accepted start edge to the done cycle is 2*lim_r*cyc_r + 1 edges, plus paused edges.
- Back-to-back runs: start may be accepted on the first IDLE cycle after DONE.

Decomposition:
- Shared package sweep_ctrl_pkg holds:
  - state encoding constants: IDLE=2'd0, UP=2'd1, DOWN=2'd2, DONE=2'd3;
  - default BITS and CYC_BITS values.
- One natural sub-module: updown_count_core.
  - Ports: clk, reset, clear, enable, up, Q.
  - Synchronous active-high reset; clear has priority over enable.
  - Instantiated once. The controller FSM, latch registers and sweep counter stay in the top module.

Test Plan:
- Basic sweep: reset, then start with limit=3, cycles=1.
  - count follows 0,1,2,3,2,1,0 on successive edges.
  - up=1 for the first 3 counting edges, then 0.
  - done high for exactly one cycle, 7 edges after the start edge; busy low afterwards.
- Repeat: limit=2, cycles=3.
  - count follows 0,1,2,1,0,1,2,1,0,1,2,1,0.
  - sweep_cnt steps 1,2,3.
  - done pulses once, 13 edges after start.
- Degenerate: start with limit=0, cycles=5.
  - Next state DONE; done pulses on the following cycle; count stays 0.
  - Repeat with limit=4, cycles=0: same result.
- Pause and ignored start: limit=4, cycles=1.
  - Assert pause for 3 cycles at count=2 (UP): count holds 2 and enable=0.
  - Pulse start during the pause with limit=9: it has no effect.
  - Peak stays 4; done is delayed by exactly 3 cycles.
- Reset mid-run: limit=5, cycles=2; assert reset at count=3 in DOWN of sweep 1.
  - Next edge: state IDLE, count=0, sweep_cnt=0, busy=0, and no done pulse.
- Full range: BITS=4, limit=15, cycles=1.
  - count peaks at 15 with no wrap to 0, then returns to 0.
  - done arrives 31 edges after start.
